sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. Successor to the fixed 32x1024 sync_fifo, with configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Used as the general-purpose buffer between same-clock producer/consumer blocks. Optional first-word-fall-through read mode.

Parameters:
DATA_W, 32, data word width in bits (>=1)
DEPTH, 1024, number of storage words; power of two, >=4
AF_LVL, DEPTH-4, almostFull asserts when count >= AF_LVL (1..DEPTH)
AE_LVL, 4, almostEmpty asserts when count <= AE_LVL (0..DEPTH-1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
wEn  input  1  write request
wData  input  DATA_W  write data
rEn  input  1  read request / acknowledge (FWFT)
rData  output  DATA_W  read data
empty  output  1  no readable word
full  output  1  DEPTH words stored
almostFull  output  1  count >= AF_LVL
almostEmpty  output  1  count <= AE_LVL
count  output  $clog2(DEPTH)+1  words currently held
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1 at a clk edge): pointers=0, count=0, rData=0, empty=1, full=0, almostEmpty=1, almostFull=0, overflow=0, underflow=0. Reset mid-operation discards all contents; a wEn/rEn in the reset cycle is ignored.
- Pointers ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); MSB is wrap bit. full = (addresses equal, wrap bits differ); empty = pointers equal. Wrap from DEPTH-1 to 0 is natural modulo.
- All flags and count are registered and reflect state after the current edge; no combinational path from wEn/rEn to any output.
- Write accepted (wAcc) = wEn & (!full | rAcc). Write while full with a simultaneous accepted read is accepted; otherwise a write while full is dropped and sets overflow.
- Read accepted (rAcc) = rEn & !empty. A read while empty is ignored and sets underflow, even if wEn is high that cycle (no bypass).
- count += wAcc - rAcc each cycle; simultaneous accepted read and write leaves count unchanged.
- Standard mode: rData is registered and updated on the edge after which rAcc was sampled, i.e. the data is valid in the cycle following rEn (1-cycle latency). rData holds its value when no read is accepted.
- overflow and underflow clear only on rst.

Optional Feature:
FWFT_EN: when defined, the FIFO operates in first-word-fall-through mode. rData presents the head word whenever empty=0, and rEn acts as an acknowledge/pop. A write into an empty FIFO makes the word visible on rData, with empty=0, in the cycle after the write edge. After an acknowledge, the next word appears in the following cycle, or empty asserts if none remains. count includes the word shown on rData. Without FWFT_EN, the standard 1-cycle registered read described above applies. Flag, count and error semantics are identical in both modes.

Decomposition:
- Package fifo_pkg: clog2 constant function and a pointer-width helper constant.
- Sub-module fifo_ram: simple dual-port RAM with one synchronous write port and one synchronous read port, parameterised by DATA_W and DEPTH. No reset on storage.
- The top level holds pointers, count, flags and the FWFT output stage.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, then release -> empty=1, full=0, count=0, almostEmpty=1, rData=0, overflow=0, underflow=0.
- Fill (DEPTH=16, AF_LVL=12): write 16 words 0x100..0x10F -> almostFull rises after the 12th write, full=1 after the 16th, count=16; a 17th write sets overflow=1 and count stays 16.
- Drain in order: read 16 words -> rData sequence 0x100..0x10F at 1-cycle latency (or at 0 latency under FWFT_EN); empty=1 after the last read; a further rEn sets underflow=1.
- Simultaneous read/write at full: while full, assert wEn and rEn together with wData=0xAA -> both accepted, count stays 16, and 0xAA emerges last.
- Wrap-around: run 1000 cycles of random wEn/rEn at 50% against a scoreboard model (DEPTH=16) -> data matches, count equals the model, no overflow or underflow is flagged when the requests were legal.
- Reset mid-operation: 8 words held, assert rst for 1 cycle -> count=0, empty=1, and the next read after a single new write returns that new word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO.
// Sizing functions used to derive address and pointer widths.
package fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Pointers carry one extra wrap bit above the address.
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEF_PTR_W = ptr_w(1024);

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// Storage is not reset; only the read register is cleared.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, almost flags and sticky errors.
// Define FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AF_LVL = DEPTH - 4,
  parameter int AE_LVL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wEn,
  input  logic [DATA_W-1:0]       wData,
  input  logic                    rEn,
  output logic [DATA_W-1:0]       rData,
  output logic                    empty,
  output logic                    full,
  output logic                    almostFull,
  output logic                    almostEmpty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [AW:0] AF_C = AF_LVL[AW:0];
  localparam logic [AW:0] AE_C = AE_LVL[AW:0];

  logic [PW-1:0] wptr, rptr, wptr_n, rptr_n;
  logic [AW:0]   count_n;
  logic          wAcc, rAcc;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_q;

  assign rAcc = rEn & ~empty;
  assign wAcc = wEn & (~full | rAcc);

  assign wptr_n  = wptr + {{(PW-1){1'b0}}, wAcc};
  assign rptr_n  = rptr + {{(PW-1){1'b0}}, rAcc};
  assign count_n = count + {{AW{1'b0}}, wAcc}
                 - {{AW{1'b0}}, rAcc};

  assign ram_we = wAcc & ~rst;

`ifdef FWFT_EN
  logic              byp_n, byp_q;
  logic [DATA_W-1:0] byp_d;

  // Prefetch the next head; a write landing on it bypasses the RAM.
  assign ram_raddr = rptr_n[AW-1:0];
  assign ram_re    = ~rst & (wptr_n != rptr_n);
  assign byp_n     = wAcc & (wptr[AW-1:0] == rptr_n[AW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q <= 1'b0;
      byp_d <= '0;
    end else begin
      byp_q <= byp_n;
      if (byp_n) byp_d <= wData;
    end
  end

  assign rData = byp_q ? byp_d : ram_q;
`else
  assign ram_raddr = rptr[AW-1:0];
  assign ram_re    = rAcc & ~rst;
  assign rData     = ram_q;
`endif

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wptr[AW-1:0]),
    .wdata (wData),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almostFull  <= 1'b0;
      almostEmpty <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      count       <= count_n;
      empty       <= (wptr_n == rptr_n);
      full        <= (wptr_n[AW] != rptr_n[AW])
                   && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      almostFull  <= (count_n >= AF_C);
      almostEmpty <= (count_n <= AE_C);
      if (wEn & ~wAcc) overflow  <= 1'b1;
      if (rEn & empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed and random checks of sync_fifo_param against a queue model.
// Honours FWFT_EN for the read-data timing.
module tb_sync_fifo_param;

  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic clk = 1'b0;
  logic rst, wEn, rEn;
  logic [DW-1:0] wData, rData;
  logic empty, full, almostFull, almostEmpty;
  logic [4:0] count;
  logic overflow, underflow;

  int checks = 0;
  int errors = 0;

  int q[$];
  bit ovf_m, unf_m;
  logic [DW-1:0] exp_rd;

  sync_fifo_param #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .AF_LVL (AF),
    .AE_LVL (AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wEn         (wEn),
    .wData       (wData),
    .rEn         (rEn),
    .rData       (rData),
    .empty       (empty),
    .full        (full),
    .almostFull  (almostFull),
    .almostEmpty (almostEmpty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".af"}, 32'(almostFull), 32'(n >= AF));
    chk({tag, ".ae"}, 32'(almostEmpty), 32'(n <= AE));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ovf_m));
    chk({tag, ".unf"}, 32'(underflow), 32'(unf_m));
`ifdef FWFT_EN
    if (n > 0) chk({tag, ".rdata"}, 32'(rData), 32'(q[0]));
`else
    chk({tag, ".rdata"}, 32'(rData), 32'(exp_rd));
`endif
  endtask

  // One clock: drive, update the model from pre-edge state, then check.
  task automatic cycle(input bit rs, input bit w, input bit r,
                       input logic [DW-1:0] d, input string tag);
    int n;
    bit ra, wa;
    rst = rs; wEn = w; rEn = r; wData = d;
    @(posedge clk);
    n = q.size();
    if (rs) begin
      q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
      exp_rd = '0;
    end else begin
      ra = r && (n > 0);
      wa = w && ((n < DEPTH) || ra);
      if (w && !wa) ovf_m = 1'b1;
      if (r && n == 0) unf_m = 1'b1;
      if (ra) exp_rd = DW'(q.pop_front());
      if (wa) q.push_back(int'(d));
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    bit rw, rr;
    rst = 1'b1; wEn = 1'b0; rEn = 1'b0; wData = '0;
    exp_rd = '0; ovf_m = 1'b0; unf_m = 1'b0;

    cycle(1, 1, 1, 16'h0BAD, "rst0");
    cycle(1, 0, 0, 16'h0, "rst1");
    cycle(1, 0, 0, 16'h0, "rst2");
    cycle(0, 0, 0, 16'h0, "idle");
    chk("idle.rdata0", 32'(rData), 32'h0);

    for (int i = 0; i < DEPTH; i++)
      cycle(0, 1, 0, DW'(16'h100 + i), "fill");
    cycle(0, 1, 0, 16'h0DEF, "ovf");

    for (int i = 0; i < DEPTH; i++) begin
`ifdef FWFT_EN
      chk("drain.head", 32'(rData), 32'(16'h100 + i));
`endif
      cycle(0, 0, 1, 16'h0, "drain");
`ifndef FWFT_EN
      chk("drain.seq", 32'(rData), 32'(16'h100 + i));
`endif
    end
    cycle(0, 0, 1, 16'h0, "unf");

    cycle(1, 0, 0, 16'h0, "rst3");
    for (int i = 0; i < DEPTH; i++)
      cycle(0, 1, 0, DW'(16'h200 + i), "refill");
    cycle(0, 1, 1, 16'h00AA, "simul");
    chk("simul.count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      cycle(0, 0, 1, 16'h0, "drain2");
    chk("simul.last", 32'(rData), 32'h00AA);

    cycle(1, 0, 0, 16'h0, "rst4");
    for (int i = 0; i < 1000; i++) begin
      rr = ($urandom_range(0, 1) == 1) && (q.size() > 0);
      rw = ($urandom_range(0, 1) == 1) && ((q.size() < DEPTH) || rr);
      cycle(0, rw, rr, DW'($urandom), "rand");
    end

    while (q.size() < 8) cycle(0, 1, 0, DW'($urandom), "pre");
    while (q.size() > 8) cycle(0, 0, 1, 16'h0, "pre");
    cycle(1, 0, 0, 16'h0, "midrst");
    chk("midrst.count", 32'(count), 32'h0);
    cycle(0, 1, 0, 16'h05A5, "neww");
`ifdef FWFT_EN
    chk("neww.head", 32'(rData), 32'h05A5);
`endif
    cycle(0, 0, 1, 16'h0, "newr");
`ifndef FWFT_EN
    chk("newr.data", 32'(rData), 32'h05A5);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
